dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target for the CPU's load/store port; the responder end of a valid/ready request–response protocol.
- Accepts one word-aligned read or write request at a time and models memory latency with a programmable number of wait states.
- Returns a response carrying read data and an error flag.
- Sits between the core's load/store unit and on-chip word-addressed SRAM storage; replaces the zero-latency combinational data memory.

Parameters:
- DEPTH, 1024, number of 32-bit words stored; must be a power of two.
- WAIT_CYCLES, 2, wait-state cycles between request acceptance and response valid; legal range 0..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errored accesses.
- resp_err  output  1  access error (misaligned, or out of range when the optional feature is enabled).

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Storage array is not reset; contents are undefined after power-up.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture write, addr, wdata, be in the accept cycle. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
- WAIT: req_ready=0; the counter decrements each cycle; at 0, go to RESP.
- Array access happens on the WAIT→RESP (or IDLE→RESP) transition edge:
  - Store: writes the enabled bytes.
  - Load: registers the word into resp_rdata.
- RESP: resp_valid=1 and req_ready=0. Outputs stay stable until resp_ready=1, then go to IDLE. resp_valid drops the following cycle; resp_rdata and resp_err clear to 0 at the same time.
- Latency: request accept to resp_valid = WAIT_CYCLES+1 cycles. No back-to-back overlap; the next request is accepted at the earliest one cycle after the response handshake.
- Word index = addr[log2(DEPTH)+1:2].
- Misaligned access (addr[1:0]!=0): no array write; resp_err=1, resp_rdata=0; same latency as a normal access.
- Store with be=4'b0000: no bytes change; resp_err=0.
- resp_ready held high while in WAIT has no effect.
- A write in RESP followed by a read of the same address returns the written data; there is no read-during-write hazard because the transactions are serialized.
- rst asserted mid-transaction: the transaction is abandoned with no response. A store is dropped if reset arrives before the array-write edge. After reset the FSM is in IDLE.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: any addr with a nonzero bit above bit log2(DEPTH)+1 gives resp_err=1, no write, resp_rdata=0, with normal latency.
- Undefined: the upper address bits are ignored and addresses wrap modulo DEPTH*4 bytes.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10 -> load response rdata=0xDEADBEEF, err=0; resp_valid rises exactly 3 cycles after accept (WAIT_CYCLES=2).
- Store 0x20=0x11223344 be=F, store 0x20=0xAABBCCDD be=4'b0101, load 0x20 -> rdata=0x11BB33DD.
- Load addr=0x22 -> resp_err=1, rdata=0; memory at 0x20 unchanged on the next aligned load.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable, req_ready=0 throughout; accept happens on the cycle resp_ready=1, and req_ready=1 the next cycle.
- DEPTH=1024, store 0x1004=0x55:
  - With DMEM_BOUNDS_CHECK_EN: resp_err=1, and a load of 0x4 does not return 0x55.
  - Without it: resp_err=0, and a load of 0x4 returns 0x55.
- Assert rst during WAIT of a store to 0x30 (prior value 0x1) -> no response; after release req_ready=1, and a load of 0x30 returns 0x1.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the CPU load/store port.
// Responder side of a valid/ready request-response protocol. It accepts
// one word-aligned read or write at a time, inserts WAIT_CYCLES wait
// states, then presents a response with read data and an error flag.
// Optional build macro DMEM_BOUNDS_CHECK_EN: when defined, any address with
// a nonzero bit above the word-index field is reported as an error. When it
// is undefined, those upper bits are ignored and addresses wrap modulo
// DEPTH*4 bytes.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    // The counter is preloaded with one less than the wait-state count so
    // that reaching zero marks the last WAIT cycle.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          access_fire;
    logic          use_live;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic          mem_we;

    assign accept     = (state == IDLE) && req_valid;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero wait states the array is accessed on the accept edge
    // itself, before the capture registers hold the request, so the live
    // request fields are used while still in IDLE.
    assign use_live  = (state == IDLE);
    assign acc_write = use_live ? req_write : cap_write;
    assign acc_addr  = use_live ? req_addr  : cap_addr;
    assign acc_wdata = use_live ? req_wdata : cap_wdata;
    assign acc_be    = use_live ? req_be    : cap_be;

    assign misaligned = |acc_addr[1:0];
    assign word_idx   = acc_addr[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign out_of_range = |acc_addr[31:AW+2];
`else
    logic unused_upper_addr;
    assign out_of_range      = 1'b0;
    assign unused_upper_addr = ^acc_addr[31:AW+2];
`endif

    assign acc_err = misaligned | out_of_range;
    assign mem_we  = access_fire && acc_write && !acc_err;

    // Next-state logic; access_fire marks the edge that enters RESP, which
    // is where the array is read or written.
    always_comb begin
        state_next  = state;
        access_fire = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next  = RESP;
                        access_fire = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next  = RESP;
                    access_fire = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request fields in the accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Wait-state counter: loaded on accept and counts down while in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response registers: loaded on the access edge, held through RESP,
    // cleared together with the response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access_fire) begin
            err_q   <= acc_err;
            rdata_q <= (acc_write || acc_err) ? 32'd0 : mem[word_idx];
        end else if ((state == RESP) && resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // Storage array is not reset; a store writes only its enabled bytes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed testbench for dmem_responder with the default
// parameters (DEPTH=1024, WAIT_CYCLES=2). Expectations for the wrap/bounds
// case follow the DMEM_BOUNDS_CHECK_EN build macro.
module tb_dmem_responder;

    localparam int EXP_LATENCY = 3;
    localparam int TIMEOUT     = 20;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int numCompared;
    int numMismatched;

    dmem_responder #(
        .DEPTH       (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction: present the request, measure latency, optionally
    // hold off the response for some cycles, then handshake and check cleanup.
    task automatic applyStimulus(input string tag, input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int holdCycles, input logic earlyReady);
        int lat;
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = write;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = earlyReady;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        checkOutput({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
        while (!resp_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            resp_ready = 1'b0;
            return;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(EXP_LATENCY));
        for (int h = 0; h < holdCycles; h++) begin
            checkOutput({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            checkOutput({tag, "_hold_rdata"}, resp_rdata, expRdata);
            checkOutput({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, expErr});
            checkOutput({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        checkOutput({tag, "_rdata"}, resp_rdata, expRdata);
        checkOutput({tag, "_err"}, {31'd0, resp_err}, {31'd0, expErr});
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_rdata_clear"}, resp_rdata, 32'd0);
        checkOutput({tag, "_err_clear"}, {31'd0, resp_err}, 32'd0);
        checkOutput({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    // Directed test sequence
    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_rdata", resp_rdata, 32'd0);
        checkOutput("reset_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;

        // Basic store then load, load with resp_ready raised early
        applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1);

        // Partial byte-enable merge
        applyStimulus("st20a", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus("st20b", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0, 1'b0);

        // Misaligned accesses and empty byte-enable leave memory untouched
        applyStimulus("ld22", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
        applyStimulus("st21", 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0, 1'b0);
        applyStimulus("st20z", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus("ld20b", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0, 1'b0);

        // Response held off for 5 cycles
        applyStimulus("hold", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5, 1'b0);

        // Out-of-range address: error with bounds check, wrap without
        applyStimulus("st04", 1'b1, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        applyStimulus("st1004", 1'b1, 32'h1004, 32'h55, 4'hF, 32'h0, 1'b1, 0, 1'b0);
        applyStimulus("ld04", 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
`else
        applyStimulus("st1004", 1'b1, 32'h1004, 32'h55, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        applyStimulus("ld04", 1'b0, 32'h4, 32'h0, 4'h0, 32'h55, 1'b0, 0, 1'b0);
`endif

        // Reset during WAIT of a store drops the store and the response
        applyStimulus("st30", 1'b1, 32'h30, 32'h1, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        checkOutput("rst_after_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 32'h1, 1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
